// File: rtl/usr_counter_pkg.sv
// Shared definitions for usr_counter: the 3-bit operation select and its encodings.
package usr_counter_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_SHR  = 3'd1;
  localparam mode_t MODE_SHL  = 3'd2;
  localparam mode_t MODE_LOAD = 3'd3;
  localparam mode_t MODE_ROR  = 3'd4;
  localparam mode_t MODE_ROL  = 3'd5;
  localparam mode_t MODE_UP   = 3'd6;
  localparam mode_t MODE_DOWN = 3'd7;

endpackage

// File: rtl/usr_counter_next.sv
// Next-state logic for usr_counter (purely combinational).
// Ports:
//   q       current register contents
//   mode    operation select
//   pin     parallel load data
//   lsin    serial input into q[0] on shift-left
//   rsin    serial input into q[WIDTH-1] on shift-right
//   q_next  register value after the next enabled edge
//   tc_raw  terminal count before enable gating
module usr_counter_next
  import usr_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 2 ** WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] pin,
  input  logic             lsin,
  input  logic             rsin,
  output logic [WIDTH-1:0] q_next,
  output logic             tc_raw
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  // One bit wider so MODULUS = 2**WIDTH is representable; q can then never reach it.
  localparam logic [WIDTH:0]   ModVal = (WIDTH + 1)'(MODULUS);

  logic at_top;
  logic at_bottom;

  always_comb begin
    at_top    = (q >= MaxVal);
    // Loaded values >= MODULUS are treated as wrap points so DOWN recovers into range.
    at_bottom = (q == '0) || ({1'b0, q} >= ModVal);
  end

  always_comb begin
    q_next = q;
    tc_raw = 1'b0;
    unique case (mode)
      MODE_HOLD: q_next = q;
      MODE_SHR:  q_next = {rsin, q[WIDTH-1:1]};
      MODE_SHL:  q_next = {q[WIDTH-2:0], lsin};
      MODE_LOAD: q_next = pin;
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_UP: begin
        q_next = at_top ? '0 : q + WIDTH'(1);
        tc_raw = at_top;
      end
      MODE_DOWN: begin
        q_next = at_bottom ? MaxVal : q - WIDTH'(1);
        tc_raw = at_bottom;
      end
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/usr_counter.sv
// Universal shift register / modulo up-down counter with clock enable.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset, clears q
//   en     clock enable; q holds when low
//   mode   operation select (see usr_counter_pkg)
//   pin    parallel load data
//   lsin   serial input on shift-left
//   rsin   serial input on shift-right
//   q      register contents
//   lsout  q[WIDTH-1]
//   rsout  q[0]
//   tc     terminal count: high in the cycle whose next edge wraps the count
module usr_counter
  import usr_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 2 ** WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] pin,
  input  logic             lsin,
  input  logic             rsin,
  output logic [WIDTH-1:0] q,
  output logic             lsout,
  output logic             rsout,
  output logic             tc
);

  // WIDTH is capped at 31 so 2**WIDTH fits the 32-bit parameter arithmetic.
  if (WIDTH < 2 || WIDTH > 31 || MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_param
    $error("usr_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_raw;

  usr_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q      (q_q),
    .mode   (mode),
    .pin    (pin),
    .lsin   (lsin),
    .rsin   (rsin),
    .q_next (q_d),
    .tc_raw (tc_raw)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  // tc is deliberately not masked by reset: DOWN with q=0 during reset reports a wrap.
  always_comb begin
    q     = q_q;
    lsout = q_q[WIDTH-1];
    rsout = q_q[0];
    tc    = en & tc_raw;
  end

endmodule

// File: tb/tb_usr_counter.sv
// Scoreboard bench for usr_counter: stimulus pushes hand-computed expectations,
// a monitor drains and compares them on each falling edge or on demand.
module tb_usr_counter;
  import usr_counter_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  mode_t      mode;
  logic [7:0] pin;
  logic       lsin;
  logic       rsin;

  logic [7:0] q0, q1;
  logic       ls0, ls1, rs0, rs1, tc0, tc1;

  always #10 clock = ~clock;

  usr_counter #(.WIDTH(8), .MODULUS(10)) dut0 (
    .clock (clock), .reset (reset), .en (en), .mode (mode), .pin (pin),
    .lsin (lsin), .rsin (rsin), .q (q0), .lsout (ls0), .rsout (rs0), .tc (tc0)
  );

  usr_counter #(.WIDTH(8), .MODULUS(256)) dut1 (
    .clock (clock), .reset (reset), .en (en), .mode (mode), .pin (pin),
    .lsin (lsin), .rsin (rsin), .q (q1), .lsout (ls1), .rsout (rs1), .tc (tc1)
  );

  typedef struct {
    string      name;
    bit         dut;
    bit         chk_q;
    logic [7:0] q;
    bit         chk_tc;
    logic       tc;
  } exp_t;

  exp_t sb[$];
  event sample_now;
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string nm, input bit d, input bit cq, input logic [7:0] eq,
                      input bit ct, input logic et);
    exp_t e;
    e.name = nm; e.dut = d; e.chk_q = cq; e.q = eq; e.chk_tc = ct; e.tc = et;
    sb.push_back(e);
  endtask

  // Monitor: q checks include the serial outputs, which must mirror q's end bits.
  initial begin
    forever begin
      @(negedge clock or sample_now);
      while (sb.size() > 0) begin
        exp_t       e;
        logic [7:0] aq;
        logic       als, ars, atc;
        e   = sb.pop_front();
        aq  = e.dut ? q1 : q0;
        als = e.dut ? ls1 : ls0;
        ars = e.dut ? rs1 : rs0;
        atc = e.dut ? tc1 : tc0;
        checks++;
        if (e.chk_q && (aq !== e.q || als !== e.q[7] || ars !== e.q[0])) begin
          errors++;
          $display("FAIL %s: got q=%h lsout=%b rsout=%b, want q=%h lsout=%b rsout=%b",
                   e.name, aq, als, ars, e.q, e.q[7], e.q[0]);
        end
        if (e.chk_tc && atc !== e.tc) begin
          errors++;
          $display("FAIL %s: got tc=%b, want tc=%b", e.name, atc, e.tc);
        end
      end
    end
  end

  // Called at posedge+1: drive inputs, expect tc for this cycle, then q after the edge.
  task automatic cyc(input string nm, input bit d, input logic e_in, input mode_t m,
                     input logic [7:0] p, input logic ls, input logic rs,
                     input logic etc, input logic [7:0] eq);
    en = e_in; mode = m; pin = p; lsin = ls; rsin = rs;
    push({nm, " tc"}, d, 1'b0, 8'h00, 1'b1, etc);
    @(posedge clock);
    #1;
    push({nm, " q"}, d, 1'b1, eq, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = MODE_HOLD; pin = '0; lsin = 1'b0; rsin = 1'b0;
    #1;
    push("reset state", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    push("reset state m256", 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;

    // Count up to 7, then reset asynchronously between edges.
    for (int i = 1; i <= 7; i++) begin
      cyc("count to 7", 1'b0, 1'b1, MODE_UP, 8'h00, 1'b0, 1'b0, 1'b0, 8'(i));
    end
    @(negedge clock); #1;
    reset = 1'b1;
    #1;
    push("async reset", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    ->sample_now;
    #1 mode = MODE_DOWN;
    #1;
    push("tc down in reset", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    ->sample_now;
    #1;
    en = 1'b0; mode = MODE_UP; reset = 1'b0;
    @(posedge clock); #1;
    cyc("resume after reset", 1'b0, 1'b1, MODE_UP, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01);

    // Load, shifts, rotates, hold.
    cyc("load A5", 1'b0, 1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5);
    cyc("shr rsin1", 1'b0, 1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1, 1'b0, 8'hD2);
    cyc("shl lsin0", 1'b0, 1'b1, MODE_SHL, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA4);
    cyc("load 81", 1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81);
    cyc("rol", 1'b0, 1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03);
    cyc("ror 1", 1'b0, 1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0, 1'b0, 8'h81);
    cyc("ror 2", 1'b0, 1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC0);
    cyc("hold", 1'b0, 1'b1, MODE_HOLD, 8'h55, 1'b1, 1'b1, 1'b0, 8'hC0);

    // Up-count wrap at modulus 10: tc only while q=9.
    cyc("load 0", 1'b0, 1'b1, MODE_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      cyc("up wrap", 1'b0, 1'b1, MODE_UP, 8'h00, 1'b0, 1'b0, 1'(i == 10), 8'(i % 10));
    end

    // Down wrap and out-of-range recovery.
    cyc("load 0 b", 1'b0, 1'b1, MODE_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc("down from 0", 1'b0, 1'b1, MODE_DOWN, 8'h00, 1'b0, 1'b0, 1'b1, 8'h09);
    cyc("down 9", 1'b0, 1'b1, MODE_DOWN, 8'h00, 1'b0, 1'b0, 1'b0, 8'h08);
    cyc("load F0", 1'b0, 1'b1, MODE_LOAD, 8'hF0, 1'b0, 1'b0, 1'b0, 8'hF0);
    cyc("down from F0", 1'b0, 1'b1, MODE_DOWN, 8'h00, 1'b0, 1'b0, 1'b1, 8'h09);
    cyc("load F0 b", 1'b0, 1'b1, MODE_LOAD, 8'hF0, 1'b0, 1'b0, 1'b0, 8'hF0);
    cyc("up from F0", 1'b0, 1'b1, MODE_UP, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);

    // Enable low: q at the wrap point must hold and tc must stay low.
    cyc("load 9", 1'b0, 1'b1, MODE_LOAD, 8'h09, 1'b0, 1'b0, 1'b0, 8'h09);
    for (int i = 0; i < 5; i++) begin
      cyc("en0 up", 1'b0, 1'b0, MODE_UP, 8'h00, 1'b0, 1'b0, 1'b0, 8'h09);
    end
    cyc("en0 load", 1'b0, 1'b0, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h09);

    // Full modulus (256) instance: natural binary wrap both ways.
    cyc("m256 load FF", 1'b1, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF);
    cyc("m256 up FF", 1'b1, 1'b1, MODE_UP, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
    cyc("m256 down 0", 1'b1, 1'b1, MODE_DOWN, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF);
    cyc("m256 down FF", 1'b1, 1'b1, MODE_DOWN, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFE);
    cyc("m256 up FE", 1'b1, 1'b1, MODE_UP, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF);

    en = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usr_counter.md
# usr_counter

Parametrised universal shift register and modulo counter: a WIDTH-bit register with hold, left/right shift, left/right rotate, parallel load and modulo up/down count. It generalises the team's fixed 4-bit shift register and free-running counters into one reusable block, for datapath shifters, serialisers and programmable dividers. It adds a clock enable, serial outputs and a terminal-count flag.

## Interface
- WIDTH, 8: register width in bits; must be at least 2.
- MODULUS, 2**WIDTH: count modulus; counting stays in 0..MODULUS-1; legal range 2..2**WIDTH.

- clock  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-high; clock clock.
- en  input  1  clock enable; when low, q holds regardless of mode.
- mode  input  3  operation select (encodings under Operation).
- pin  input  WIDTH  parallel load data.
- lsin  input  1  serial input shifted into q[0] on shift-left.
- rsin  input  1  serial input shifted into q[WIDTH-1] on shift-right.
- q  output  WIDTH  register contents.
- lsout  output  1  equals q[WIDTH-1], the bit leaving on shift-left.
- rsout  output  1  equals q[0], the bit leaving on shift-right.
- tc  output  1  terminal count, combinational; see Operation.

## Operation
Mode encodings and next-state rules (apply only when en=1):
- 0 HOLD: q unchanged.
- 1 SHR: q ← {rsin, q[WIDTH-1:1]}.
- 2 SHL: q ← {q[WIDTH-2:0], lsin}.
- 3 LOAD: q ← pin. Any value is accepted, including values ≥ MODULUS.
- 4 ROR: q ← {q[0], q[WIDTH-1:1]}.
- 5 ROL: q ← {q[WIDTH-2:0], q[WIDTH-1]}.
- 6 UP: if q ≥ MODULUS-1 then q ← 0, else q ← q+1.
- 7 DOWN: if q = 0 or q ≥ MODULUS then q ← MODULUS-1, else q ← q-1.

Arithmetic and flag rules:
- Arithmetic is WIDTH bits wide; no carry or borrow escapes q.
- When MODULUS = 2**WIDTH, UP and DOWN are natural binary wrap.
- tc = en & ((mode=UP & q ≥ MODULUS-1) | (mode=DOWN & (q=0 | q ≥ MODULUS))).
- tc is high in exactly the cycle whose next edge wraps the count.
- tc is 0 in all other modes.
- lsout and rsout are continuous functions of q and do not depend on en or mode.

## Timing
- All q updates occur on the rising edge of clock; latency is one cycle from inputs to q.
- Mode, en, pin and the serial inputs are sampled at the edge.
- tc, lsout and rsout are combinational from the current q, mode and en; there are no extra pipeline stages.
- Reset: asynchronous assert, q = 0 immediately, mid-operation included.
  - While reset is high: lsout = 0, rsout = 0, tc = 0.
  - Exception: if en=1 and mode=DOWN during reset, tc = 1 because q = 0. This is intended and must not be masked.
- Reset release is synchronous to the clock by the integrating design. The first edge after release applies the current mode.
- en=0 has priority over every mode except reset.
- Changing mode between edges has no effect until the next edge; there is no internal mode state.

## Structure
- Package usr_counter_pkg holds:
  - localparam mode constants MODE_HOLD..MODE_DOWN (3-bit);
  - a typedef for the 3-bit mode.
- Both the block and its bench import the package.
- One combinational sub-module, usr_counter_next, computes the next q and tc from q, mode, pin and the serial inputs.
- The top keeps only the state register, the enable gating and reset.
- MODULUS legality is checked at elaboration with a generate-time error.

## Test plan
All scenarios use WIDTH=8, MODULUS=10 unless stated.
1. Reset check: reset pulse mid-count with q=7 → q=0 at once, without waiting for a clock edge; count resumes from 0 after release.
2. LOAD and shifts: LOAD pin=8'hA5 → q=A5.
   - SHR with rsin=1 → q=D2, rsout was 1.
   - SHL with lsin=0 → q=A4.
3. Rotates: LOAD 8'h81.
   - ROL → q=03.
   - ROR twice → q=C0.
4. Up-count wrap: UP from 0 for 12 edges → q sequence 1..9, 0, 1, 2; tc high only while q=9.
5. Down-count and out-of-range: DOWN from 0 → q=9, with tc high before that edge.
   - LOAD 8'hF0 then DOWN → q=9 (out-of-range recovery).
   - LOAD 8'hF0 then UP → q=0.
6. Enable and full modulus: en=0 with mode=UP for 5 edges → q unchanged and tc=0.
   - Repeat with MODULUS=256 and q=FF, UP → q=00 with tc=1 beforehand.
